// File: rtl/dequeue_scheduler_if.sv
// Handshake bundle between the queue table, the dequeue engine and the round-robin scheduler.
// master = scheduler side, slave = queue table / engine side.
interface dequeue_scheduler_if #(
    parameter int NUM_Q      = 8,
    parameter int QID_WIDTH  = 3,
    parameter int DATA_WIDTH = 20
);
    logic [NUM_Q-1:0]            q_valid;
    logic [NUM_Q*DATA_WIDTH-1:0] q_head_ptr;
    logic                        pcp_queue_full;
    logic                        deq_start;
    logic [DATA_WIDTH-1:0]       deq_head_ptr;
    logic                        deq_done;
    logic [DATA_WIDTH-1:0]       deq_new_head;
    logic [15:0]                 deq_rd_depth;
    logic                        upd_valid;
    logic [QID_WIDTH-1:0]        upd_qid;
    logic [DATA_WIDTH-1:0]       upd_head;
    logic [15:0]                 upd_cells;
    logic                        busy;
    logic                        timeout_err;
    logic [31:0]                 grant_count;

    modport master (
        input  q_valid, q_head_ptr, pcp_queue_full, deq_done, deq_new_head, deq_rd_depth,
        output deq_start, deq_head_ptr, upd_valid, upd_qid, upd_head, upd_cells,
               busy, timeout_err, grant_count
    );

    modport slave (
        output q_valid, q_head_ptr, pcp_queue_full, deq_done, deq_new_head, deq_rd_depth,
        input  deq_start, deq_head_ptr, upd_valid, upd_qid, upd_head, upd_cells,
               busy, timeout_err, grant_count
    );
endinterface

// File: rtl/dequeue_scheduler.sv
// Round-robin scheduler sharing one dequeue engine among NUM_Q flow queues, with a
// watchdog that aborts a dequeue whose done pulse never arrives.
module dequeue_scheduler #(
    parameter int NUM_Q      = 8,
    parameter int QID_WIDTH  = 3,
    parameter int DATA_WIDTH = 20,
    parameter int HOLDOFF    = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    dequeue_scheduler_if.master  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int HD_W = $clog2(HOLDOFF + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_UPDATE  = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    logic [2:0]            state;
    logic [QID_WIDTH-1:0]  rr_last;
    logic [WD_W-1:0]       wd;
    logic [HD_W-1:0]       hold_cnt;
    logic [DATA_WIDTH-1:0] head_r;
    logic [QID_WIDTH-1:0]  qid_r;
    logic [DATA_WIDTH-1:0] upd_head_r;
    logic [15:0]           cells_r;
    logic [31:0]           count_r;

    // Lowest valid index above rr_last wins; otherwise wrap to the lowest valid index.
    logic                  any_hi;
    logic [QID_WIDTH-1:0]  pick_hi, pick_lo, win_qid;
    logic [DATA_WIDTH-1:0] head_hi, head_lo, win_head;

    always_comb begin
        any_hi  = 1'b0;
        pick_hi = '0;
        pick_lo = '0;
        head_hi = '0;
        head_lo = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (bus.q_valid[i]) begin
                pick_lo = QID_WIDTH'(i);
                head_lo = bus.q_head_ptr[i*DATA_WIDTH +: DATA_WIDTH];
                if (i > int'(rr_last)) begin
                    any_hi  = 1'b1;
                    pick_hi = QID_WIDTH'(i);
                    head_hi = bus.q_head_ptr[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        win_qid  = any_hi ? pick_hi : pick_lo;
        win_head = any_hi ? head_hi : head_lo;
    end

    wire wd_limit = (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_last    <= QID_WIDTH'(NUM_Q - 1);
            wd         <= '0;
            hold_cnt   <= '0;
            head_r     <= '0;
            qid_r      <= '0;
            upd_head_r <= '0;
            cells_r    <= '0;
            count_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|bus.q_valid && !bus.pcp_queue_full) begin
                        rr_last <= win_qid;
                        qid_r   <= win_qid;
                        head_r  <= win_head;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over the watchdog when both land together
                    if (bus.deq_done) begin
                        cells_r <= bus.deq_rd_depth;
                        state   <= S_CAPTURE;
                    end else if (wd_limit) begin
                        state <= S_HOLD;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_CAPTURE: begin
                    upd_head_r <= bus.deq_new_head;
                    state      <= S_UPDATE;
                end
                S_UPDATE: begin
                    count_r <= count_r + 32'd1;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt == HD_W'(HOLDOFF - 1)) begin
                        hold_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HD_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.deq_start    = (state == S_ISSUE);
    assign bus.deq_head_ptr = head_r;
    assign bus.upd_valid    = (state == S_UPDATE);
    assign bus.upd_qid      = qid_r;
    assign bus.upd_head     = upd_head_r;
    assign bus.upd_cells    = cells_r;
    assign bus.busy         = (state != S_IDLE);
    assign bus.timeout_err  = (state == S_WAIT) && !bus.deq_done && wd_limit;
    assign bus.grant_count  = count_r;
endmodule

// File: tb/tb_dequeue_scheduler.sv
// Bench for dequeue_scheduler: arbitration vector table, hand-written corner sequences and a
// randomized run against a transaction-level timing model.
module tb_dequeue_scheduler;
    localparam int NQ   = 8;
    localparam int QW   = 3;
    localparam int DW   = 20;
    localparam int HOLD = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dequeue_scheduler_if #(.NUM_Q(NQ), .QID_WIDTH(QW), .DATA_WIDTH(DW)) bus ();
    dequeue_scheduler #(.NUM_Q(NQ), .QID_WIDTH(QW), .DATA_WIDTH(DW), .HOLDOFF(HOLD), .TIMEOUT(TMO))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] heads [NQ];

    typedef struct {
        logic [NQ-1:0] qv;
        int            qid;
    } vec_t;
    vec_t tbl [16];

    // transaction model state
    int m_free, m_start, m_lat, m_upd, m_to, m_rr, m_cnt, m_qid;
    logic [DW-1:0] m_head, m_nh;
    logic [15:0]   m_dep;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NQ-1:0] v, input int last);
        for (int k = 1; k <= NQ; k++)
            if (v[(last + k) % NQ]) return (last + k) % NQ;
        return -1;
    endfunction

    task automatic set_heads();
        for (int i = 0; i < NQ; i++) bus.q_head_ptr[i*DW +: DW] = heads[i];
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, 32'(bus.deq_start), 32'd0);
        chk({tag, "_ptr"},   32'(bus.deq_head_ptr), 32'd0);
        chk({tag, "_upd"},   32'(bus.upd_valid), 32'd0);
        chk({tag, "_qid"},   32'(bus.upd_qid), 32'd0);
        chk({tag, "_head"},  32'(bus.upd_head), 32'd0);
        chk({tag, "_cells"}, 32'(bus.upd_cells), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_tmo"},   32'(bus.timeout_err), 32'd0);
        chk({tag, "_cnt"},   bus.grant_count, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.q_valid = '0;
        bus.pcp_queue_full = 1'b0;
        bus.deq_done = 1'b0;
        bus.deq_new_head = '0;
        bus.deq_rd_depth = '0;
        @(negedge clk);
        check_zero("rst");
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        logic seen = 1'b0;
        for (int k = 0; k < 60; k++)
            if (!seen) begin
                @(negedge clk);
                seen = bus.deq_start;
            end
        chk({nm, "_start_seen"}, 32'(seen), 32'd1);
    endtask

    // Engine response: called at the negedge of the deq_start cycle.
    task automatic serve(input int lat, input logic [15:0] dep, input logic [DW-1:0] nh, input int qid);
        repeat (lat) @(posedge clk);
        #1 bus.deq_done = 1'b1;
        bus.deq_rd_depth = dep;
        @(negedge clk);
        chk("srv_no_tmo", 32'(bus.timeout_err), 32'd0);
        @(posedge clk);
        #1 bus.deq_done = 1'b0;
        bus.deq_new_head = nh;
        bus.deq_rd_depth = 16'hBEEF;
        @(negedge clk);
        chk("srv_upd_early", 32'(bus.upd_valid), 32'd0);
        @(posedge clk);
        #1 bus.deq_new_head = ~nh;
        @(negedge clk);
        chk("srv_upd", 32'(bus.upd_valid), 32'd1);
        chk("srv_qid", 32'(bus.upd_qid), 32'(qid));
        chk("srv_head", 32'(bus.upd_head), 32'(nh));
        chk("srv_cells", 32'(bus.upd_cells), 32'(dep));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int d;
        logic in_wait;
        bus.q_head_ptr = '0;
        heads[0] = 20'h00005;
        for (int i = 1; i < NQ; i++) heads[i] = 20'hA0000 + DW'(i) * 20'h111;
        set_heads();

        // 1/2: idle after reset, single frame with exact latencies
        do_reset();
        bus.deq_done = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_start", 32'(bus.deq_start), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            bus.deq_done = 1'b0;
        end
        bus.q_valid = 8'h01;
        @(negedge clk);
        chk("t2_start", 32'(bus.deq_start), 32'd1);
        chk("t2_ptr", 32'(bus.deq_head_ptr), 32'h00005);
        bus.q_valid = '0;
        serve(1, 16'd3, 20'h0C00A, 0);
        @(negedge clk);
        chk("t2_cnt", bus.grant_count, 32'd1);

        // arbitration table
        tbl[0] = '{8'hFF, 0};  tbl[1] = '{8'hFF, 1};  tbl[2] = '{8'hFF, 2};  tbl[3] = '{8'hFF, 3};
        tbl[4] = '{8'hFF, 4};  tbl[5] = '{8'hFF, 5};  tbl[6] = '{8'hFF, 6};  tbl[7] = '{8'hFF, 7};
        tbl[8] = '{8'hFF, 0};  tbl[9] = '{8'hFF, 1};  tbl[10] = '{8'h24, 2}; tbl[11] = '{8'h24, 5};
        tbl[12] = '{8'h24, 2}; tbl[13] = '{8'h81, 7}; tbl[14] = '{8'h81, 0}; tbl[15] = '{8'h01, 0};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.q_valid = tbl[i].qv;
            wait_start($sformatf("tbl%0d", i));
            bus.q_valid = '0;
            chk($sformatf("tbl%0d_ptr", i), 32'(bus.deq_head_ptr), 32'(heads[tbl[i].qid]));
            chk($sformatf("tbl%0d_qid", i), 32'(bus.upd_qid), 32'(tbl[i].qid));
            serve(1 + i % 3, 16'(i + 1), 20'h50000 + DW'(i), tbl[i].qid);
            @(negedge clk);
            chk($sformatf("tbl%0d_cnt", i), bus.grant_count, 32'(i + 1));
        end

        // 4: pcp_queue_full blocks grants
        do_reset();
        bus.pcp_queue_full = 1'b1;
        bus.q_valid = 8'h24;
        repeat (20) begin
            @(negedge clk);
            chk("full_no_start", 32'(bus.deq_start), 32'd0);
        end
        bus.pcp_queue_full = 1'b0;
        @(negedge clk);
        chk("full_start", 32'(bus.deq_start), 32'd1);
        chk("full_ptr2", 32'(bus.deq_head_ptr), 32'(heads[2]));
        serve(3, 16'd9, 20'h12345, 2);
        wait_start("full_q5");
        bus.q_valid = '0;
        chk("full_ptr5", 32'(bus.deq_head_ptr), 32'(heads[5]));
        serve(2, 16'hFFFF, 20'hFFFFF, 5);

        // 5: watchdog abort, then the aborted queue loses priority
        do_reset();
        bus.q_valid = 8'h01;
        wait_start("tmo");
        bus.q_valid = '0;
        for (int k = 1; k <= TMO + HOLD + 1; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_pulse_k%0d", k), 32'(bus.timeout_err), 32'(k == TMO));
            chk("tmo_no_upd", 32'(bus.upd_valid), 32'd0);
            chk($sformatf("tmo_busy_k%0d", k), 32'(bus.busy), 32'(k <= TMO + HOLD));
        end
        chk("tmo_cnt", bus.grant_count, 32'd0);
        bus.q_valid = 8'h03;
        wait_start("tmo_next");
        bus.q_valid = '0;
        chk("tmo_next_qid", 32'(bus.upd_qid), 32'd1);
        // done exactly at the watchdog limit wins
        serve(TMO, 16'd7, 20'h0ABCD, 1);

        // 6: reset during WAIT
        do_reset();
        bus.q_valid = 8'hFF;
        wait_start("rstw");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_zero("rstw");
        @(posedge clk);
        #1 reset = 1'b0;
        wait_start("rstw_after");
        chk("rstw_ptr", 32'(bus.deq_head_ptr), 32'(heads[0]));
        chk("rstw_qid", 32'(bus.upd_qid), 32'd0);
        bus.q_valid = '0;
        serve(2, 16'd1, 20'h00042, 0);

        // randomized run against the transaction model
        do_reset();
        m_free = cyc; m_start = -1000; m_lat = 0; m_upd = -1000; m_to = -1000;
        m_rr = NQ - 1; m_cnt = 0; m_qid = 0; m_head = '0; m_nh = '0; m_dep = '0;
        repeat (2500) begin
            @(posedge clk);
            #1 d = cyc;
            in_wait = (d > m_start) && (d <= m_start + ((m_lat < TMO) ? m_lat : TMO));
            if (d == m_start + m_lat) begin
                bus.deq_done = 1'b1;
                bus.deq_rd_depth = m_dep;
            end else begin
                bus.deq_done = !in_wait && ($urandom % 8 == 0);
                bus.deq_rd_depth = 16'($urandom);
            end
            bus.deq_new_head = (d == m_start + m_lat + 1) ? m_nh : DW'($urandom);
            if ($urandom % 4 == 0) bus.q_valid = NQ'($urandom);
            bus.pcp_queue_full = ($urandom % 5 == 0);
            heads[$urandom % NQ] = DW'($urandom);
            set_heads();
            @(negedge clk);
            chk("r_start", 32'(bus.deq_start), 32'(d == m_start));
            chk("r_ptr", 32'(bus.deq_head_ptr), 32'(m_head));
            chk("r_qid", 32'(bus.upd_qid), 32'(m_qid));
            chk("r_upd", 32'(bus.upd_valid), 32'(d == m_upd));
            if (d == m_upd) begin
                chk("r_head", 32'(bus.upd_head), 32'(m_nh));
                chk("r_cells", 32'(bus.upd_cells), 32'(m_dep));
            end
            chk("r_tmo", 32'(bus.timeout_err), 32'(d == m_to));
            chk("r_busy", 32'(bus.busy), 32'(d >= m_start && d < m_free));
            chk("r_cnt", bus.grant_count, 32'(m_cnt));
            if (d == m_upd) m_cnt++;
            if (d >= m_free && |bus.q_valid && !bus.pcp_queue_full) begin
                m_qid   = rr_pick(bus.q_valid, m_rr);
                m_rr    = m_qid;
                m_head  = heads[m_qid];
                m_start = d + 1;
                m_lat   = $urandom_range(1, 20);
                m_dep   = 16'($urandom);
                m_nh    = DW'($urandom);
                if (m_lat <= TMO) begin
                    m_upd  = m_start + m_lat + 2;
                    m_to   = -1000;
                    m_free = m_upd + 1 + HOLD;
                end else begin
                    m_upd  = -1000;
                    m_to   = m_start + TMO;
                    m_free = m_to + 1 + HOLD;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
